// File: rtl/amm_wm_pkg.sv
// Shared types and constants for the amm_write_master Avalon-MM write engine.
package amm_wm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WORD_BYTES = 4;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/amm_wm_fifo.sv
// Synchronous word FIFO; head word is visible the cycle after it is pushed.
module amm_wm_fifo
    import amm_wm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      pop,
    output logic [WIDTH-1:0]          data_out,
    output logic [fifo_ptr_w(DEPTH):0] count,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = fifo_ptr_w(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == (PW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign data_out = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a push is dropped even when a pop frees a slot.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_in;
    end

endmodule

// File: rtl/amm_write_master.sv
// Avalon-MM single-word write master fed by a user push FIFO.
// Optional sticky overflow flag enabled with `define AMM_WM_OVERFLOW_EN.
module amm_write_master
    import amm_wm_pkg::*;
#(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32,
    parameter int FIFO_DEPTH   = 32
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]  control_write_base,
    input  logic [ADDRESSWIDTH-1:0]  control_write_length,
    input  logic                     control_go,
    output logic                     control_done,
    input  logic                     user_write_buffer,
    input  logic [DATAWIDTH-1:0]     user_buffer_data,
    output logic                     user_buffer_full,
    output logic [ADDRESSWIDTH-1:0]  master_address,
    output logic                     master_write,
    output logic [DATAWIDTH/8-1:0]   master_byteenable,
    output logic [DATAWIDTH-1:0]     master_writedata,
    input  logic                     master_waitrequest
`ifdef AMM_WM_OVERFLOW_EN
    ,
    output logic                     overflow
`endif
);

    localparam int CW = ADDRESSWIDTH - 2;
    localparam int PW = fifo_ptr_w(FIFO_DEPTH);

    state_t                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]           remaining_q, remaining_d;
    logic                    fixed_q, fixed_d;
    logic                    done_q, done_d;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [PW:0]             fifo_count;
    logic                    accept;
    logic [CW-1:0]           go_words;
    logic                    unused_bits;

    amm_wm_fifo #(
        .WIDTH (DATAWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (user_write_buffer),
        .data_in  (user_buffer_data),
        .pop      (accept),
        .data_out (master_writedata),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign unused_bits = ^{fifo_count, control_write_length[1:0]};

    // Write request is decoded from registered state only, so it cannot change while stalled.
    assign master_write      = (state_q == RUN) && !fifo_empty && (remaining_q != '0);
    assign accept            = master_write && !master_waitrequest;
    assign master_address    = addr_q;
    assign master_byteenable = '1;
    assign control_done      = done_q;
    assign user_buffer_full  = fifo_full;
    assign go_words          = control_write_length[ADDRESSWIDTH-1:2];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        fixed_d     = fixed_q;
        done_d      = done_q;
        case (state_q)
            IDLE: begin
                if (control_go) begin
                    addr_d  = control_write_base;
                    fixed_d = control_fixed_location;
                    if (go_words != '0) begin
                        remaining_d = go_words;
                        state_d     = RUN;
                        done_d      = 1'b0;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    remaining_d = remaining_q - 1'b1;
                    if (!fixed_q) addr_d = addr_q + ADDRESSWIDTH'(WORD_BYTES);
                    if (remaining_q == CW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            fixed_q     <= 1'b0;
            done_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            fixed_q     <= fixed_d;
            done_q      <= done_d;
        end
    end

`ifdef AMM_WM_OVERFLOW_EN
    logic overflow_q, overflow_d;

    // A dropped push in the same cycle as a go still leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (state_q == IDLE && control_go) overflow_d = 1'b0;
        if (user_write_buffer && fifo_full) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_amm_write_master.sv
// Directed self-checking bench for amm_write_master (default FIFO_DEPTH=32).
module tb_amm_write_master;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        control_fixed_location = 1'b0;
    logic [27:0] control_write_base = '0;
    logic [27:0] control_write_length = '0;
    logic        control_go = 1'b0;
    logic        control_done;
    logic        user_write_buffer = 1'b0;
    logic [31:0] user_buffer_data = '0;
    logic        user_buffer_full;
    logic [27:0] master_address;
    logic        master_write;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata;
    logic        master_waitrequest = 1'b0;
`ifdef AMM_WM_OVERFLOW_EN
    logic        overflow;
`endif

    int total = 0;
    int bad = 0;
    int accepts = 0;
    int a0 = 0;

    amm_write_master dut (
        .clk                    (clk),
        .n_rst                  (n_rst),
        .control_fixed_location (control_fixed_location),
        .control_write_base     (control_write_base),
        .control_write_length   (control_write_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .user_write_buffer      (user_write_buffer),
        .user_buffer_data       (user_buffer_data),
        .user_buffer_full       (user_buffer_full),
        .master_address         (master_address),
        .master_write           (master_write),
        .master_byteenable      (master_byteenable),
        .master_writedata       (master_writedata),
        .master_waitrequest     (master_waitrequest)
`ifdef AMM_WM_OVERFLOW_EN
        ,
        .overflow               (overflow)
`endif
    );

    always #5 clk = ~clk;

    // Inputs only change just after a rising edge, so the falling edge sees what the next rising edge will.
    always @(negedge clk) begin
        if (n_rst && master_write && !master_waitrequest) accepts++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] data);
        user_write_buffer = 1'b1;
        user_buffer_data  = data;
        tick();
        user_write_buffer = 1'b0;
    endtask

    task automatic go(input logic [27:0] base, input logic [27:0] len, input logic fixed);
        control_write_base     = base;
        control_write_length   = len;
        control_fixed_location = fixed;
        control_go             = 1'b1;
        tick();
        control_go             = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_write"}, 32'(master_write), 32'd1);
        check({tag, "_addr"}, 32'(master_address), addr);
        check({tag, "_data"}, master_writedata, data);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        check("rst_done", 32'(control_done), 32'd1);
        check("rst_write", 32'(master_write), 32'd0);
        check("rst_addr", 32'(master_address), 32'h0);
        check("rst_full", 32'(user_buffer_full), 32'd0);
        check("rst_be", 32'(master_byteenable), 32'hF);
        n_rst = 1'b1;
        tick();

        // Basic: prefilled while idle, back-to-back writes
        for (int i = 0; i < 4; i++) push(32'hA000_0000 + 32'(i));
        check("idle_hold_write", 32'(master_write), 32'd0);
        check("idle_hold_done", 32'(control_done), 32'd1);
        a0 = accepts;
        go(28'h100, 28'd16, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("basic_done_low", 32'(control_done), 32'd0);
            expect_write("basic", 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            tick();
        end
        check("basic_done_end", 32'(control_done), 32'd1);
        check("basic_write_end", 32'(master_write), 32'd0);
        check("basic_accepts", 32'(accepts - a0), 32'd4);

        // Stall on second word for three cycles
        for (int i = 0; i < 4; i++) push(32'hB000_0000 + 32'(i));
        a0 = accepts;
        go(28'h100, 28'd16, 1'b0);
        expect_write("stall_w0", 32'h100, 32'hB000_0000);
        tick();
        master_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_write("stall_hold", 32'h104, 32'hB000_0001);
            tick();
        end
        master_waitrequest = 1'b0;
        expect_write("stall_w1", 32'h104, 32'hB000_0001);
        tick();
        expect_write("stall_w2", 32'h108, 32'hB000_0002);
        tick();
        expect_write("stall_w3", 32'h10C, 32'hB000_0003);
        tick();
        check("stall_done", 32'(control_done), 32'd1);
        check("stall_accepts", 32'(accepts - a0), 32'd4);

        // Fixed location with a starved source
        go(28'h200, 28'd8, 1'b1);
        check("fixed_done_low", 32'(control_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("fixed_empty_write", 32'(master_write), 32'd0);
            tick();
        end
        push(32'hC000_0000);
        expect_write("fixed_w0", 32'h200, 32'hC000_0000);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("fixed_gap_write", 32'(master_write), 32'd0);
            check("fixed_gap_done", 32'(control_done), 32'd0);
            tick();
        end
        push(32'hC000_0001);
        expect_write("fixed_w1", 32'h200, 32'hC000_0001);
        tick();
        check("fixed_done", 32'(control_done), 32'd1);
        check("fixed_write_end", 32'(master_write), 32'd0);

        // Zero length, then odd length 6 -> one word
        a0 = accepts;
        go(28'h400, 28'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("zero_done", 32'(control_done), 32'd1);
            check("zero_write", 32'(master_write), 32'd0);
            tick();
        end
        push(32'hD000_0000);
        go(28'h400, 28'd6, 1'b0);
        check("odd_done_low", 32'(control_done), 32'd0);
        expect_write("odd_w0", 32'h400, 32'hD000_0000);
        tick();
        check("odd_done", 32'(control_done), 32'd1);
        check("odd_accepts", 32'(accepts - a0), 32'd1);

        // Fill past depth while idle; 33rd word is dropped
        for (int i = 0; i < 33; i++) begin
            push(32'hE000_0000 + 32'(i));
            if (i == 30) check("fill31_full", 32'(user_buffer_full), 32'd0);
            if (i == 31) check("fill32_full", 32'(user_buffer_full), 32'd1);
`ifdef AMM_WM_OVERFLOW_EN
            if (i == 31) check("fill32_ovf", 32'(overflow), 32'd0);
`endif
        end
        check("fill33_full", 32'(user_buffer_full), 32'd1);
`ifdef AMM_WM_OVERFLOW_EN
        check("fill33_ovf", 32'(overflow), 32'd1);
`endif
        go(28'h500, 28'd128, 1'b0);
`ifdef AMM_WM_OVERFLOW_EN
        check("ovf_cleared", 32'(overflow), 32'd0);
`endif
        for (int i = 0; i < 32; i++) begin
            if (i == 1) check("drain_full_low", 32'(user_buffer_full), 32'd0);
            expect_write("drain", 32'h500 + 32'(4 * i), 32'hE000_0000 + 32'(i));
            tick();
        end
        check("drain_done", 32'(control_done), 32'd1);
        go(28'h600, 28'd4, 1'b0);
        check("dropped_write", 32'(master_write), 32'd0);
        tick();
        check("dropped_write2", 32'(master_write), 32'd0);
        check("dropped_done", 32'(control_done), 32'd0);

        // Clean restart, then reset during a stalled second write
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push(32'hF000_0000 + 32'(i));
        go(28'h700, 28'd16, 1'b0);
        expect_write("rr_w0", 32'h700, 32'hF000_0000);
        tick();
        master_waitrequest = 1'b1;
        tick();
        expect_write("rr_w1", 32'h704, 32'hF000_0001);
        #2;
        n_rst = 1'b0;
        #1;
        check("rr_write", 32'(master_write), 32'd0);
        check("rr_done", 32'(control_done), 32'd1);
        check("rr_full", 32'(user_buffer_full), 32'd0);
        check("rr_addr", 32'(master_address), 32'h0);
        master_waitrequest = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        push(32'h6000_0001);
        go(28'h300, 28'd4, 1'b0);
        expect_write("rr_new", 32'h300, 32'h6000_0001);
        tick();
        check("rr_new_done", 32'(control_done), 32'd1);

        // Address wrap at the top of the space; a go while running is ignored
        push(32'h7000_0000);
        push(32'h7000_0001);
        go(28'hFFF_FFFC, 28'd8, 1'b0);
        expect_write("wrap_w0", 32'hFFF_FFFC, 32'h7000_0000);
        control_write_base   = 28'h900;
        control_write_length = 28'd100;
        control_go           = 1'b1;
        tick();
        control_go = 1'b0;
        expect_write("wrap_w1", 32'h0, 32'h7000_0001);
        tick();
        check("wrap_done", 32'(control_done), 32'd1);
        check("wrap_write_end", 32'(master_write), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
